// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: gates the receiver reset, checks each completed
// frame, buffers good bytes in a small FIFO and reports sticky errors.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                      baud_clk,
  input  logic                      rst,
  input  logic                      rx_en,
  input  logic [10:0]               frame_in,
  input  logic                      frame_valid,
  output logic                      rx_rst_n,
  output logic [7:0]                rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  input  logic                      err_clr,
  output logic                      parity_err,
  output logic                      framing_err,
  output logic                      start_err,
  output logic                      overrun_err,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            fv_q;
  logic [10:0]     frame_q;
  logic            bad_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;

  logic rise_c, load_c, check_c, store_c;
  logic p_ok_c, full_c, pop_c, push_c, ovr_set_c;

  assign rise_c    = frame_valid & ~fv_q;
  assign p_ok_c    = ~PARITY_EN | ((^frame_q[9:1]) == PARITY_ODD);
  assign full_c    = (level_q == LW'(DEPTH));
  assign rd_valid  = (level_q != '0);
  assign rd_data   = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign pop_c     = rd_valid & rd_ready;
  assign push_c    = store_c & ~bad_q & (~full_c | pop_c);
  // A good frame with nowhere to go, or a new frame while one is in flight
  assign ovr_set_c = (store_c & ~bad_q & full_c & ~pop_c) |
                     (rx_en & rise_c & (state_q != ST_WAIT));

  // State register
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) state_q <= ST_WAIT;
    else      state_q <= state_d;
  end

  // Next-state and per-state strobes; disabling receive parks the FSM
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    check_c = 1'b0;
    store_c = 1'b0;
    if (!rx_en) begin
      state_d = ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (rise_c) begin
            load_c  = 1'b1;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          check_c = 1'b1;
          state_d = ST_STORE;
        end
        ST_STORE: begin
          store_c = 1'b1;
          state_d = ST_WAIT;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  // Frame capture, verdict register, edge history and receiver reset gate
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      fv_q     <= 1'b0;
      frame_q  <= '0;
      bad_q    <= 1'b0;
      rx_rst_n <= 1'b0;
    end else begin
      fv_q     <= frame_valid;
      rx_rst_n <= rx_en;
      if (load_c)  frame_q <= frame_in;
      if (check_c) bad_q   <= frame_q[0] | ~p_ok_c | ~frame_q[10];
    end
  end

  // Sticky error flags; a set on the same edge as a clear takes priority
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      start_err   <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      start_err   <= (start_err   & ~err_clr) | (check_c & frame_q[0]);
      parity_err  <= (parity_err  & ~err_clr) | (check_c & ~p_ok_c);
      framing_err <= (framing_err & ~err_clr) | (check_c & ~frame_q[10]);
      overrun_err <= (overrun_err & ~err_clr) | ovr_set_c;
    end
  end

  // Data FIFO storage, pointers and occupancy
  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= frame_q[8:1];
        wr_ptr_q        <= AW'(wr_ptr_q + 1'b1);
      end
      if (pop_c) rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
      level_q <= level_q + LW'(push_c) - LW'(pop_c);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an even-parity and an odd-parity instance share the
// frame stimulus and are checked against a transaction-level model.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic        baud_clk = 1'b0;
  logic        rst, rx_en, frame_valid, err_clr;
  logic [10:0] frame_in;
  logic [1:0]  rd_ready;

  logic          rx_rst_n [2];
  logic [7:0]    rd_data [2];
  logic          rd_valid [2];
  logic          parity_err [2], framing_err [2], start_err [2], overrun_err [2];
  logic [LW-1:0] fifo_level [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Model state per instance (index 0 = even parity, 1 = odd parity)
  logic [7:0] mq [2][DEPTH];
  int         mcnt [2];
  bit         m_par [2], m_frm [2], m_st [2], m_ovr [2];

  always #5 baud_clk = ~baud_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    uart_rx_ctrl #(.DEPTH(DEPTH), .PARITY_EN(1'b1), .PARITY_ODD(g == 1)) u_dut (
      .baud_clk    (baud_clk),
      .rst         (rst),
      .rx_en       (rx_en),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .rx_rst_n    (rx_rst_n[g]),
      .rd_data     (rd_data[g]),
      .rd_valid    (rd_valid[g]),
      .rd_ready    (rd_ready[g]),
      .err_clr     (err_clr),
      .parity_err  (parity_err[g]),
      .framing_err (framing_err[g]),
      .start_err   (start_err[g]),
      .overrun_err (overrun_err[g]),
      .fifo_level  (fifo_level[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Build a frame for a data byte; the bad_* knobs corrupt individual fields
  function automatic logic [10:0] mk(input logic [7:0] d, input bit odd,
                                     input bit bad_s, input bit bad_p, input bit bad_f);
    bit par;
    par = (($countones(d) % 2) == 1) ^ odd ^ bad_p;
    return {~bad_f, par, d, bad_s};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      m_par[d] = 0; m_frm[d] = 0; m_st[d] = 0; m_ovr[d] = 0;
      for (int i = 0; i < int'(DEPTH); i++) mq[d][i] = 8'h00;
    end
  endtask

  task automatic model_pop(input int d);
    for (int i = 0; i < mcnt[d] - 1; i++) mq[d][i] = mq[d][i+1];
    mcnt[d]--;
  endtask

  task automatic model_clr();
    for (int d = 0; d < 2; d++) begin
      m_par[d] = 0; m_frm[d] = 0; m_st[d] = 0; m_ovr[d] = 0;
    end
  endtask

  // One whole frame: verdict, then a host read offered on the store edge
  task automatic model_frame(input logic [10:0] f, input logic [1:0] mask);
    bit pok, good, full_pre, pop;
    for (int d = 0; d < 2; d++) begin
      pok  = (($countones(f[9:1]) % 2) == d);
      good = !f[0] && pok && f[10];
      if (f[0])   m_st[d]  = 1;
      if (!pok)   m_par[d] = 1;
      if (!f[10]) m_frm[d] = 1;
      full_pre = (mcnt[d] == int'(DEPTH));
      pop      = mask[d] && (mcnt[d] > 0);
      if (pop) model_pop(d);
      if (good) begin
        if (full_pre && !pop) m_ovr[d] = 1;
        else begin
          mq[d][mcnt[d]] = f[8:1];
          mcnt[d]++;
        end
      end
    end
  endtask

  task automatic check_all(input string where);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s[%0d] level", where, d), 32'(fifo_level[d]), 32'(mcnt[d]));
      chk($sformatf("%s[%0d] valid", where, d), 32'(rd_valid[d]), 32'(mcnt[d] > 0));
      chk($sformatf("%s[%0d] errs", where, d),
          {28'd0, start_err[d], parity_err[d], framing_err[d], overrun_err[d]},
          {28'd0, m_st[d], m_par[d], m_frm[d], m_ovr[d]});
      if (mcnt[d] > 0)
        chk($sformatf("%s[%0d] data", where, d), 32'(rd_data[d]), 32'(mq[d][0]));
    end
  endtask

  // Present a frame with frame_valid held for 'hold' cycles; rd_ready=mask on
  // the store edge; err_clr pulsed on the check edge when clr is set
  task automatic send(input logic [10:0] f, input int hold, input logic [1:0] mask,
                      input bit clr, input string tag);
    int last;
    last = (hold > 4) ? hold : 4;
    @(negedge baud_clk);
    frame_in = f;
    frame_valid = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge baud_clk);
      if (k == hold) frame_valid = 1'b0;
      if (k == 1 || k == 2)
        for (int d = 0; d < 2; d++)
          chk($sformatf("%s[%0d] pre-store valid", tag, d), 32'(rd_valid[d]), 32'(mcnt[d] > 0));
      if (k == 1) err_clr = clr;
      if (k == 2) begin
        err_clr  = 1'b0;
        rd_ready = mask;
      end
      if (k == 3) begin
        rd_ready = 2'b00;
        if (clr) model_clr();
        model_frame(f, mask);
        check_all(tag);
      end
    end
  endtask

  task automatic drain(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge baud_clk);
      chk($sformatf("drain[%0d] valid", d), 32'(rd_valid[d]), 32'(mcnt[d] > 0));
      if (mcnt[d] > 0) chk($sformatf("drain[%0d] data", d), 32'(rd_data[d]), 32'(mq[d][0]));
      rd_ready[d] = 1'b1;
      @(negedge baud_clk);
      rd_ready[d] = 1'b0;
      if (mcnt[d] > 0) model_pop(d);
    end
  endtask

  task automatic pulse_clr();
    @(negedge baud_clk);
    err_clr = 1'b1;
    @(negedge baud_clk);
    err_clr = 1'b0;
    model_clr();
  endtask

  initial begin
    rst = 1'b0; rx_en = 1'b0; frame_valid = 1'b0; err_clr = 1'b0;
    frame_in = '0; rd_ready = 2'b00;
    model_reset();
    repeat (2) @(negedge baud_clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset[%0d] rx_rst_n", d), 32'(rx_rst_n[d]), 32'd0);
      chk($sformatf("reset[%0d] rd_data", d), 32'(rd_data[d]), 32'd0);
    end
    check_all("reset");
    rst = 1'b1;
    rx_en = 1'b1;
    @(negedge baud_clk);
    chk("enable rx_rst_n", 32'(rx_rst_n[0]), 32'd1);

    // Basic good frame, latency and pop
    send(11'h4AA, 1, 2'b00, 1'b0, "t1");
    chk("t1 data55", 32'(rd_data[0]), 32'h55);
    drain(0, 1);
    check_all("t1 popped");

    // Parity, framing and start errors, then clear
    send(11'h6AA, 1, 2'b00, 1'b0, "t2");
    drain(1, 1);
    send(11'h0AA, 1, 2'b00, 1'b0, "t3 stop");
    send(11'h4AB, 1, 2'b00, 1'b0, "t3 start");
    pulse_clr();
    check_all("t3 clr");

    // Overflow with no reads, then in-order drain
    for (int i = 1; i <= 5; i++) send(mk(8'(i), 1'b0, 0, 0, 0), 1, 2'b00, 1'b0, "t4");
    drain(0, 4);
    check_all("t4 drained");
    pulse_clr();

    // Full FIFO with a pop on the store edge
    for (int i = 0; i < 4; i++) send(mk(8'(8'h10 + i), 1'b0, 0, 0, 0), 1, 2'b00, 1'b0, "t5 fill");
    send(11'h54A, 1, 2'b01, 1'b0, "t5 pushpop");
    drain(0, 4);
    drain(1, mcnt[1]);
    pulse_clr();

    // Long frame_valid level, set-beats-clear, and a rise during processing
    send(mk(8'h3C, 1'b0, 0, 0, 0), 5, 2'b00, 1'b0, "t6 hold");
    send(mk(8'h3C, 1'b0, 1, 0, 0), 1, 2'b00, 1'b1, "t6 setwins");
    @(negedge baud_clk); frame_in = mk(8'h66, 1'b0, 0, 0, 0); frame_valid = 1'b1;
    @(negedge baud_clk); frame_valid = 1'b0;
    @(negedge baud_clk); frame_valid = 1'b1; frame_in = mk(8'h77, 1'b0, 0, 0, 0);
    @(negedge baud_clk); frame_valid = 1'b0;
    model_frame(mk(8'h66, 1'b0, 0, 0, 0), 2'b00);
    m_ovr[0] = 1; m_ovr[1] = 1;
    repeat (2) @(negedge baud_clk);
    check_all("t6 busy rise");

    // Receive disabled: reset gate drops and frames are ignored
    @(negedge baud_clk); rx_en = 1'b0;
    @(negedge baud_clk);
    chk("t6 rx_rst_n off", 32'(rx_rst_n[0]), 32'd0);
    frame_in = mk(8'h99, 1'b0, 0, 0, 0); frame_valid = 1'b1;
    @(negedge baud_clk); frame_valid = 1'b0;
    repeat (4) @(negedge baud_clk);
    check_all("t6 disabled");
    rx_en = 1'b1;
    @(negedge baud_clk);
    chk("t6 rx_rst_n on", 32'(rx_rst_n[1]), 32'd1);

    // Reset while a frame sits in the check stage
    frame_in = mk(8'h42, 1'b0, 0, 0, 0); frame_valid = 1'b1;
    @(negedge baud_clk); frame_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t6 rst rx_rst_n", 32'(rx_rst_n[0]), 32'd0);
    chk("t6 rst rd_data", 32'(rd_data[0]), 32'd0);
    check_all("t6 rst");
    @(negedge baud_clk); rst = 1'b1;
    repeat (4) @(negedge baud_clk);
    check_all("t6 after rst");

    // Randomized frames, reads and clears
    for (int it = 0; it < 60; it++) begin
      send(mk(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0),
           $urandom_range(1, 3), 2'($urandom), $urandom_range(0, 9) == 0, "rnd");
      if ($urandom_range(0, 3) == 0) begin
        drain(0, $urandom_range(0, mcnt[0]));
        drain(1, $urandom_range(0, mcnt[1]));
      end
    end
    drain(0, mcnt[0]);
    drain(1, mcnt[1]);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
